// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a Hack ROM image over 8N1 UART and streams it into program SRAM,
// holding the CPU in reset until a complete, error-free image has been written.
module uart_prog_loader #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int BAUD          = 115200,
  parameter int ADDR_WIDTH    = 18,
  parameter int TIMEOUT_CYC   = 2_500_000,
  parameter int HOLD_AT_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rxd,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err
);
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE} state_t;

  rx_state_t             r_rx_state;
  logic                  r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CW-1:0]         r_rx_cnt;
  logic [2:0]            r_rx_bit;
  logic [7:0]            r_rx_shift;
  logic                  r_rx_valid, r_rx_ferr;
  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_data;
  logic                  r_wr_valid, r_cpu_rst_n, r_load_done, r_err;
  logic [TW-1:0]         r_timer;
  logic                  w_bit_tick, w_wait_byte, w_timeout, w_abort;

  assign w_bit_tick  = r_rx_cnt == CW'(DIV - 1);
  assign w_wait_byte = r_state inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO};
  assign w_timeout   = w_wait_byte && !r_rx_valid && r_timer == TW'(TIMEOUT_CYC - 1);
  // A framing error only aborts a frame in progress; in IDLE/DONE it just flags err.
  assign w_abort     = w_timeout || (r_rx_ferr && r_state != S_IDLE && r_state != S_DONE) ||
                       (r_rx_valid && r_state == S_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1    <= uart_rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        RX_START: if (r_rx_cnt == CW'(HALF - 1)) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + CW'(1);
        RX_DATA: begin
          r_rx_cnt <= w_bit_tick ? '0 : r_rx_cnt + CW'(1);
          if (w_bit_tick) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          r_rx_cnt <= w_bit_tick ? '0 : r_rx_cnt + CW'(1);
          if (w_bit_tick) begin
            r_rx_valid <= r_rx_s2;
            r_rx_ferr  <= !r_rx_s2;
            r_rx_state <= RX_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr_valid  <= 1'b0;
      r_cpu_rst_n <= (HOLD_AT_RESET == 0);
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_load_done <= 1'b0;
      r_timer     <= (r_rx_valid || r_state == S_IDLE) ? '0 : w_wait_byte ? r_timer + TW'(1) : r_timer;
      if (w_abort) begin
        r_err      <= 1'b1;
        r_wr_valid <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_rx_ferr) r_err <= 1'b1;
            else if (r_rx_valid && r_rx_shift == 8'h55) begin
              r_err       <= 1'b0;
              r_cpu_rst_n <= 1'b0;
              r_addr      <= '0;
              r_state     <= S_CNT_HI;
            end
          end
          S_CNT_HI: if (r_rx_valid) begin
            r_cnt[15:8] <= r_rx_shift;
            r_state     <= S_CNT_LO;
          end
          S_CNT_LO: if (r_rx_valid) begin
            r_cnt[7:0] <= r_rx_shift;
            r_state    <= {r_cnt[15:8], r_rx_shift} == 16'd0 ? S_DONE : S_DATA_HI;
          end
          S_DATA_HI: if (r_rx_valid) begin
            r_data[15:8] <= r_rx_shift;
            r_state      <= S_DATA_LO;
          end
          S_DATA_LO: if (r_rx_valid) begin
            r_data[7:0] <= r_rx_shift;
            r_wr_valid  <= 1'b1;
            r_state     <= S_WRITE;
          end
          S_WRITE: if (wr_ready) begin
            r_wr_valid <= 1'b0;
            r_addr     <= r_addr + ADDR_WIDTH'(1);
            r_cnt      <= r_cnt - 16'd1;
            r_state    <= r_cnt == 16'd1 ? S_DONE : S_DATA_HI;
          end
          S_DONE: begin
            if (r_rx_ferr) r_err <= 1'b1;
            r_load_done <= 1'b1;
            r_cpu_rst_n <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_addr;
  assign wr_data   = r_data;
  assign cpu_rst_n = r_cpu_rst_n;
  assign busy      = r_state != S_IDLE;
  assign load_done = r_load_done;
  assign err       = r_err;
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that receives a Hack ROM image over the board UART and writes it, one 16-bit word per address, into the program SRAM through the SRAM arbiter's write port. It sits upstream of the Hack core on the board clock domain (the 25 MHz VGA/PLL clock), next to the CPU and the SRAM controller. While a load is in progress it holds the CPU in reset, and it releases the CPU only after a complete, error-free image has been written.

## Interface
- CLK_FREQ, 25_000_000: clock frequency in Hz.
- BAUD, 115200: UART bit rate. DIV = CLK_FREQ/BAUD, integer-truncated, and must be at least 4.
- ADDR_WIDTH, 18: SRAM word-address width.
- TIMEOUT_CYC, 2_500_000: maximum idle gap between bytes inside a frame.
- HOLD_AT_RESET, 1: if 1, the CPU stays in reset after rst_n until the first successful load. If 0, the CPU is released from reset immediately.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- uart_rxd  in  1  UART RX line, asynchronous to clk, idle high, 8N1, LSB first.
- wr_valid  out  1  SRAM write request.
- wr_ready  in  1  arbiter accepts the write in the cycle where wr_valid && wr_ready.
- wr_addr  out  ADDR_WIDTH  word address.
- wr_data  out  16  instruction word.
- cpu_rst_n  out  1  active-low reset to the Hack core.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle pulse when an image completes.
- err  out  1  sticky error flag.

## Operation
UART receiver:
- uart_rxd passes through a 2-flop synchroniser, reset value 1.
- A falling edge while the receiver is idle starts a byte.
- At DIV/2 cycles the start bit is re-checked. If it is high, the edge was a glitch and the receiver returns to idle.
- Data bits 0..7 are sampled every DIV cycles after that point; the stop bit is sampled DIV cycles after bit 7.
- Stop bit = 1: rx_valid pulses for 1 cycle with rx_byte.
- Stop bit = 0: framing error. The byte is dropped and err is set.

Frame format: 0x55, N[15:8], N[7:0], then N words, each sent high byte first, then low byte.

Loader FSM:
- IDLE:
  - Bytes other than 0x55 are ignored.
  - On 0x55: clear err, set cpu_rst_n=0, set addr=0, go to CNT_HI.
- CNT_HI: the next byte becomes cnt[15:8]; go to CNT_LO.
- CNT_LO: the next byte becomes cnt[7:0].
  - If N==0, go to DONE.
  - Otherwise go to DATA_HI.
- DATA_HI: the byte becomes wr_data[15:8]; go to DATA_LO.
- DATA_LO: the byte becomes wr_data[7:0]; go to WRITE.
- WRITE: hold wr_valid=1 with wr_addr and wr_data stable until wr_ready. On acceptance:
  - addr += 1, cnt -= 1.
  - If cnt reaches 0, go to DONE; otherwise go to DATA_HI.
- DONE: load_done=1 for one cycle, set cpu_rst_n=1, go to IDLE.

Errors (each sets err, returns the FSM to IDLE, and leaves cpu_rst_n=0):
- Timeout: no rx_valid for TIMEOUT_CYC cycles in CNT_HI, CNT_LO, DATA_HI or DATA_LO. The timer restarts on each byte and is frozen in WRITE.
- Overrun: rx_valid arrives while in WRITE.
- Framing error: a framing error inside a frame aborts the frame. A framing error in IDLE only sets err.

Address arithmetic:
- addr is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH with no error.
- cnt is 16 bits.

Reload: a 0x55 received in IDLE while the CPU is running restarts a load and drives cpu_rst_n low.

## Timing
Reset values:
- wr_valid=0, wr_addr=0, wr_data=0, busy=0, load_done=0, err=0.
- cpu_rst_n = ~HOLD_AT_RESET.
- FSM in IDLE, receiver idle.

Receiver latency: rx_valid occurs 2 (synchroniser) + DIV/2 + 9·DIV cycles after the start-bit falling edge at the pin, ±1 cycle.

Per-byte FSM timing:
- The state update is registered on the rx_valid cycle.
- wr_valid rises in the cycle after the DATA_LO rx_valid.
- cpu_rst_n falls in the cycle after the header rx_valid.
- DONE follows the final write acceptance by 1 cycle. load_done and cpu_rst_n=1 are both visible on the cycle after DONE is entered.

Reset mid-operation: asserting rst_n returns every output to its reset value immediately, including any in-flight wr_valid. The write is abandoned.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD=100_000 (DIV=16) and TIMEOUT_CYC=1000.
- Send 55 00 02 12 34 AB CD with wr_ready tied to 1 → writes (addr 0, data 0x1234) and (addr 1, data 0xABCD); one load_done pulse; cpu_rst_n low from the header until one cycle after DONE; err=0.
- Same frame with wr_ready held low for 50 cycles on each write → wr_valid, wr_addr and wr_data stay stable for the whole stall; the same two writes occur; no error.
- Send 00 FF 55 00 00 → bytes before the header are ignored; zero writes; load_done pulses; cpu_rst_n=1.
- Send 55 00 03 12 34 and then stop the line → after 1000 idle cycles err=1, FSM in IDLE, cpu_rst_n stays 0. A following valid frame clears err.
- Send a byte whose stop bit is 0 during DATA_HI → err=1 and the frame is aborted. Send a 3-cycle low glitch on rxd → no rx_valid.
- Pulse rst_n low while wr_valid=1 → wr_valid=0 asynchronously and cpu_rst_n=0 (HOLD_AT_RESET=1). Repeat with HOLD_AT_RESET=0 → cpu_rst_n=1 after reset.
